// File: rtl/multi_ch_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// multi_ch_pulse_gen_if
// Control/data bundle between the user control registers and the multi-channel
// pulse-train generator.
//   i_trigger        per-channel start request (rising edge starts a burst)
//   i_stop           per-channel abort level
//   i_valid_amp      per-channel high-phase level
//   i_zero_amp       per-channel low-phase / idle level
//   i_data_duration  per-channel high-phase length in clocks
//   i_zero_duration  per-channel low-phase length in clocks
//   i_repeat         per-channel period count (0 = continuous)
//   i_dac_ready      shared DAC link-up indication
//   i_lmfc           shared one-clock LMFC pulse
//   o_data           packed sample lanes, channel c lane s at (c*SPC+s)
//   o_busy           per-channel burst in progress
//   o_done           per-channel one-clock completion pulse
// Modports: master = register/driver side, slave = generator side.
// -----------------------------------------------------------------------------
interface multi_ch_pulse_gen_if #(
  parameter int NUM_CH   = 4,
  parameter int SPC      = 4,
  parameter int SAMPLE_W = 16,
  parameter int DUR_W    = 32,
  parameter int RPT_W    = 16
);
  logic [NUM_CH-1:0]              i_trigger;
  logic [NUM_CH-1:0]              i_stop;
  logic [NUM_CH*SAMPLE_W-1:0]     i_valid_amp;
  logic [NUM_CH*SAMPLE_W-1:0]     i_zero_amp;
  logic [NUM_CH*DUR_W-1:0]        i_data_duration;
  logic [NUM_CH*DUR_W-1:0]        i_zero_duration;
  logic [NUM_CH*RPT_W-1:0]        i_repeat;
  logic                           i_dac_ready;
  logic                           i_lmfc;
  logic [NUM_CH*SPC*SAMPLE_W-1:0] o_data;
  logic [NUM_CH-1:0]              o_busy;
  logic [NUM_CH-1:0]              o_done;

  modport master (
    output i_trigger, i_stop, i_valid_amp, i_zero_amp, i_data_duration,
           i_zero_duration, i_repeat, i_dac_ready, i_lmfc,
    input  o_data, o_busy, o_done
  );

  modport slave (
    input  i_trigger, i_stop, i_valid_amp, i_zero_amp, i_data_duration,
           i_zero_duration, i_repeat, i_dac_ready, i_lmfc,
    output o_data, o_busy, o_done
  );
endinterface

// File: rtl/multi_ch_pulse_gen.sv
// -----------------------------------------------------------------------------
// multi_ch_pulse_gen
// Independent per-channel rectangular pulse-train generator for the AWG DAC
// path. Each channel emits D_hi clocks of its valid level followed by D_lo
// clocks of its zero level, repeated N times (or forever when N = 0).
// Ports:
//   sys_clk  user clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   bus      multi_ch_pulse_gen_if.slave (controls in, sample lanes/status out)
// Timing: the shared/control inputs pass through one register stage, the
// channel FSM follows, and o_data/o_busy/o_done are registered from the FSM
// state, so a trigger edge sampled at edge k gives valid data from edge k+2.
// -----------------------------------------------------------------------------
module multi_ch_pulse_gen #(
  parameter int NUM_CH     = 4,
  parameter int SPC        = 4,
  parameter int SAMPLE_W   = 16,
  parameter int DUR_W      = 32,
  parameter int RPT_W      = 16,
  parameter bit ALIGN_LMFC = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  multi_ch_pulse_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  // Last counter index of a phase; a zero duration behaves as one clock.
  // Subtracting instead of comparing against D keeps D = 2^DUR_W-1 wrap-free.
  function automatic logic [DUR_W-1:0] last_idx(input logic [DUR_W-1:0] dur);
    if (dur == {DUR_W{1'b0}}) begin
      last_idx = {DUR_W{1'b0}};
    end else begin
      last_idx = dur - {{(DUR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [NUM_CH-1:0] trig_hist_r;
  logic [NUM_CH-1:0] trig_edge_r;
  logic [NUM_CH-1:0] stop_r;
  logic              ready_r;
  logic              lmfc_r;

  // Input stage: trigger edge detect plus registered stop/ready/lmfc.
  // History resets to ones so a trigger held through reset never fires.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      trig_hist_r <= {NUM_CH{1'b1}};
      trig_edge_r <= {NUM_CH{1'b0}};
      stop_r      <= {NUM_CH{1'b0}};
      ready_r     <= 1'b0;
      lmfc_r      <= 1'b0;
    end else begin
      trig_hist_r <= bus.i_trigger;
      trig_edge_r <= bus.i_trigger & ~trig_hist_r;
      stop_r      <= bus.i_stop;
      ready_r     <= bus.i_dac_ready;
      lmfc_r      <= bus.i_lmfc;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_r;
    logic [DUR_W-1:0]    cnt_r;
    logic [DUR_W-1:0]    hi_last_r;
    logic [DUR_W-1:0]    lo_last_r;
    logic [RPT_W-1:0]    rpt_r;
    logic [RPT_W-1:0]    per_cnt_r;
    logic [SAMPLE_W-1:0] valid_r;
    logic [SAMPLE_W-1:0] zero_r;
    logic [SAMPLE_W-1:0] sample_r;
    logic                busy_r;
    logic                done_r;
    logic                done_flag_r;
    logic                abort_s;
    logic                more_s;
    logic [SAMPLE_W-1:0] live_zero_s;

    assign live_zero_s = bus.i_zero_amp[c*SAMPLE_W +: SAMPLE_W];
    assign abort_s     = stop_r[c] | ~ready_r;
    // Another period follows when continuous or period_count+1 < repeat.
    assign more_s      = (rpt_r == {RPT_W{1'b0}}) ||
                         (({1'b0, per_cnt_r} + {{RPT_W{1'b0}}, 1'b1}) < {1'b0, rpt_r});

    // Channel FSM with counters, parameter snapshot and registered outputs.
    always_ff @(posedge sys_clk) begin
      if (rst) begin
        state_r     <= ST_IDLE;
        cnt_r       <= {DUR_W{1'b0}};
        hi_last_r   <= {DUR_W{1'b0}};
        lo_last_r   <= {DUR_W{1'b0}};
        rpt_r       <= {RPT_W{1'b0}};
        per_cnt_r   <= {RPT_W{1'b0}};
        valid_r     <= {SAMPLE_W{1'b0}};
        zero_r      <= {SAMPLE_W{1'b0}};
        sample_r    <= {SAMPLE_W{1'b0}};
        busy_r      <= 1'b0;
        done_r      <= 1'b0;
        done_flag_r <= 1'b0;
      end else begin
        done_flag_r <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (trig_edge_r[c] && ready_r) begin
              valid_r   <= bus.i_valid_amp[c*SAMPLE_W +: SAMPLE_W];
              zero_r    <= live_zero_s;
              hi_last_r <= last_idx(bus.i_data_duration[c*DUR_W +: DUR_W]);
              lo_last_r <= last_idx(bus.i_zero_duration[c*DUR_W +: DUR_W]);
              rpt_r     <= bus.i_repeat[c*RPT_W +: RPT_W];
              per_cnt_r <= {RPT_W{1'b0}};
              cnt_r     <= {DUR_W{1'b0}};
              state_r   <= ALIGN_LMFC ? ST_ARM : ST_HIGH;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_ARM: begin
            if (abort_s) begin
              state_r <= ST_IDLE;
            end else if (lmfc_r) begin
              state_r <= ST_HIGH;
            end else begin
              state_r <= ST_ARM;
            end
          end
          ST_HIGH: begin
            if (abort_s) begin
              cnt_r   <= {DUR_W{1'b0}};
              state_r <= ST_IDLE;
            end else if (cnt_r == hi_last_r) begin
              cnt_r   <= {DUR_W{1'b0}};
              state_r <= ST_LOW;
            end else begin
              cnt_r <= cnt_r + {{(DUR_W-1){1'b0}}, 1'b1};
            end
          end
          ST_LOW: begin
            if (abort_s) begin
              cnt_r   <= {DUR_W{1'b0}};
              state_r <= ST_IDLE;
            end else if (cnt_r == lo_last_r) begin
              cnt_r <= {DUR_W{1'b0}};
              if (more_s) begin
                per_cnt_r <= per_cnt_r + {{(RPT_W-1){1'b0}}, 1'b1};
                state_r   <= ST_HIGH;
              end else begin
                done_flag_r <= 1'b1;
                state_r     <= ST_IDLE;
              end
            end else begin
              cnt_r <= cnt_r + {{(DUR_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            cnt_r   <= {DUR_W{1'b0}};
            state_r <= ST_IDLE;
          end
        endcase

        // Outputs follow the current state one clock later; o_done lands on
        // the clock where o_data returns to the idle level.
        busy_r <= (state_r != ST_IDLE);
        done_r <= done_flag_r;
        case (state_r)
          ST_HIGH:        sample_r <= valid_r;
          ST_ARM, ST_LOW: sample_r <= zero_r;
          default:        sample_r <= live_zero_s;
        endcase
      end
    end

    assign bus.o_busy[c] = busy_r;
    assign bus.o_done[c] = done_r;
    for (genvar s = 0; s < SPC; s++) begin : g_lane
      assign bus.o_data[(c*SPC+s)*SAMPLE_W +: SAMPLE_W] = sample_r;
    end
  end

endmodule

// File: tb/tb_multi_ch_pulse_gen.sv
module tb_multi_ch_pulse_gen;
  localparam int NCH = 4;
  localparam int SPC = 4;
  localparam int SW  = 16;
  localparam int DW  = 32;
  localparam int RW  = 16;

  logic sys_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;

  multi_ch_pulse_gen_if #(.NUM_CH(NCH), .SPC(SPC), .SAMPLE_W(SW), .DUR_W(DW), .RPT_W(RW)) bus_a ();
  multi_ch_pulse_gen_if #(.NUM_CH(1),   .SPC(SPC), .SAMPLE_W(SW), .DUR_W(DW), .RPT_W(RW)) bus_b ();

  multi_ch_pulse_gen #(.NUM_CH(NCH), .SPC(SPC), .SAMPLE_W(SW), .DUR_W(DW), .RPT_W(RW),
                       .ALIGN_LMFC(1'b0)) dut_a (.sys_clk(sys_clk), .rst(rst), .bus(bus_a));
  multi_ch_pulse_gen #(.NUM_CH(1), .SPC(SPC), .SAMPLE_W(SW), .DUR_W(DW), .RPT_W(RW),
                       .ALIGN_LMFC(1'b1)) dut_b (.sys_clk(sys_clk), .rst(rst), .bus(bus_b));

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] lane_a(input int c, input int s);
    return bus_a.o_data[(c*SPC+s)*SW +: SW];
  endfunction

  function automatic logic lanes_equal_a();
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int s = 1; s < SPC; s++)
        if (lane_a(c, s) !== lane_a(c, 0)) ok = 1'b0;
    return ok;
  endfunction

  task automatic cfg_a(input int c, input logic [SW-1:0] v, input logic [SW-1:0] z,
                       input logic [DW-1:0] dh, input logic [DW-1:0] dl, input logic [RW-1:0] r);
    bus_a.i_valid_amp[c*SW +: SW]     = v;
    bus_a.i_zero_amp[c*SW +: SW]      = z;
    bus_a.i_data_duration[c*DW +: DW] = dh;
    bus_a.i_zero_duration[c*DW +: DW] = dl;
    bus_a.i_repeat[c*RW +: RW]        = r;
  endtask

  initial begin
    bus_a.i_trigger = '0; bus_a.i_stop = '0; bus_a.i_valid_amp = '0; bus_a.i_zero_amp = '0;
    bus_a.i_data_duration = '0; bus_a.i_zero_duration = '0; bus_a.i_repeat = '0;
    bus_a.i_dac_ready = 1'b1; bus_a.i_lmfc = 1'b0;
    bus_b.i_trigger = '0; bus_b.i_stop = '0; bus_b.i_valid_amp = 16'h5A5A; bus_b.i_zero_amp = 16'h0101;
    bus_b.i_data_duration = 32'd2; bus_b.i_zero_duration = 32'd1; bus_b.i_repeat = 16'd1;
    bus_b.i_dac_ready = 1'b1; bus_b.i_lmfc = 1'b0;

    // Reset, with ch3 trigger held high across it
    bus_a.i_trigger[3] = 1'b1;
    rst = 1'b1;
    step(); step(); step();
    chk("rst_data_a", 64'(bus_a.o_data == '0), 64'd1);
    chk("rst_busy_a", 64'(bus_a.o_busy), 64'd0);
    chk("rst_done_a", 64'(bus_a.o_done), 64'd0);
    chk("rst_busy_b", 64'(bus_b.o_busy), 64'd0);
    rst = 1'b0;
    step(); step(); step(); step();
    chk("held_trig_no_fire", 64'(bus_a.o_busy[3]), 64'd0);
    bus_a.i_trigger[3] = 1'b0;
    step();

    // Basic burst: D_hi=3, D_lo=2, repeat=2
    cfg_a(0, 16'h7FFF, 16'h0000, 32'd3, 32'd2, 16'd2);
    bus_a.i_trigger[0] = 1'b1;
    step();
    chk("t1_data_k", 64'(lane_a(0, 0)), 64'h0);
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 1) bus_a.i_trigger[0] = 1'b0;
      chk("t1_data", 64'(lane_a(0, 0)), ((n >= 2 && n <= 4) || (n >= 7 && n <= 9)) ? 64'h7FFF : 64'h0);
      chk("t1_busy", 64'(bus_a.o_busy[0]), 64'(n >= 2 && n <= 11));
      chk("t1_done", 64'(bus_a.o_done[0]), 64'(n == 12));
    end

    // Continuous 1/1 on ch1, then stop
    cfg_a(1, 16'h1234, 16'h0055, 32'd1, 32'd1, 16'd0);
    bus_a.i_trigger[1] = 1'b1;
    step();
    bus_a.i_trigger[1] = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      step();
      if (n >= 2) begin
        chk("t2_data", 64'(lane_a(1, 0)), (n % 2 == 0) ? 64'h1234 : 64'h0055);
        chk("t2_busy", 64'(bus_a.o_busy[1]), 64'd1);
      end
      chk("t2_done", 64'(bus_a.o_done[1]), 64'd0);
    end
    bus_a.i_stop[1] = 1'b1;
    step();
    bus_a.i_stop[1] = 1'b0;
    step();
    chk("t2_stop_done_j1", 64'(bus_a.o_done[1]), 64'd0);
    step();
    chk("t2_stop_data", 64'(lane_a(1, 0)), 64'h0055);
    chk("t2_stop_busy", 64'(bus_a.o_busy[1]), 64'd0);
    chk("t2_stop_done", 64'(bus_a.o_done[1]), 64'd0);
    step();
    chk("t2_stop_done_j3", 64'(bus_a.o_done[1]), 64'd0);

    // Snapshot: amplitude change mid-burst and retrigger while busy
    cfg_a(0, 16'h1000, 16'h0000, 32'd2, 32'd2, 16'd2);
    bus_a.i_trigger[0] = 1'b1;
    step();
    bus_a.i_trigger[0] = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      step();
      chk("t4_data", 64'(lane_a(0, 0)), ((n >= 2 && n <= 3) || (n >= 6 && n <= 7)) ? 64'h1000 : 64'h0);
      chk("t4_busy", 64'(bus_a.o_busy[0]), 64'(n >= 2 && n <= 9));
      chk("t4_done", 64'(bus_a.o_done[0]), 64'(n == 10));
      if (n == 3) bus_a.i_valid_amp[0 +: SW] = 16'h2000;
      if (n == 4) bus_a.i_trigger[0] = 1'b1;
    end
    bus_a.i_trigger[0] = 1'b0;
    step();
    bus_a.i_trigger[0] = 1'b1;
    step();
    bus_a.i_trigger[0] = 1'b0;
    step(); step();
    chk("t4_new_amp", 64'(lane_a(0, 0)), 64'h2000);
    for (int n = 3; n <= 11; n++) step();
    chk("t4_second_end", 64'(bus_a.o_busy[0]), 64'd0);

    // Staggered ch2 (D_hi=0) and ch3
    cfg_a(2, 16'h0ABC, 16'h0011, 32'd0, 32'd2, 16'd1);
    cfg_a(3, 16'h3333, 16'h0000, 32'd2, 32'd1, 16'd1);
    bus_a.i_trigger[2] = 1'b1;
    step();
    for (int n = 1; n <= 7; n++) begin
      if (n == 1) bus_a.i_trigger[3] = 1'b1;
      step();
      chk("t5_ch2_data", 64'(lane_a(2, 0)), (n == 2) ? 64'h0ABC : 64'h0011);
      chk("t5_ch2_done", 64'(bus_a.o_done[2]), 64'(n == 5));
      chk("t5_ch3_data", 64'(lane_a(3, 0)), (n >= 3 && n <= 4) ? 64'h3333 : 64'h0);
      chk("t5_ch3_busy", 64'(bus_a.o_busy[3]), 64'(n >= 3 && n <= 5));
      chk("t5_ch3_done", 64'(bus_a.o_done[3]), 64'(n == 6));
      chk("t5_ch1_idle", 64'(lane_a(1, 0)), 64'h0055);
      chk("t5_lanes", 64'(lanes_equal_a()), 64'd1);
    end
    bus_a.i_trigger[3:2] = 2'b00;

    // DAC ready drop mid-burst
    cfg_a(0, 16'h4444, 16'h0000, 32'd2, 32'd2, 16'd0);
    bus_a.i_trigger[1:0] = 2'b11;
    step();
    bus_a.i_trigger[1:0] = 2'b00;
    step(); step(); step(); step();
    chk("t6_busy_before", 64'(bus_a.o_busy[1:0]), 64'd3);
    bus_a.i_dac_ready = 1'b0;
    step(); step(); step();
    chk("t6_busy_drop", 64'(bus_a.o_busy[1:0]), 64'd0);
    chk("t6_ch0_data", 64'(lane_a(0, 0)), 64'h0);
    chk("t6_ch1_data", 64'(lane_a(1, 0)), 64'h0055);
    chk("t6_done", 64'(bus_a.o_done), 64'd0);
    bus_a.i_trigger[0] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("t6_no_start", 64'(bus_a.o_busy[0]), 64'd0);
    end
    bus_a.i_trigger[0] = 1'b0;
    bus_a.i_dac_ready = 1'b1;
    step();

    // Reset mid-burst
    bus_a.i_zero_amp[0 +: SW] = 16'h0F0F;
    bus_a.i_trigger[0] = 1'b1;
    step();
    bus_a.i_trigger[0] = 1'b0;
    step(); step(); step();
    chk("t7_busy_pre", 64'(bus_a.o_busy[0]), 64'd1);
    rst = 1'b1;
    step();
    chk("t7_rst_data", 64'(bus_a.o_data == '0), 64'd1);
    chk("t7_rst_busy", 64'(bus_a.o_busy), 64'd0);
    chk("t7_rst_done", 64'(bus_a.o_done), 64'd0);
    rst = 1'b0;
    step();
    chk("t7_idle_data", 64'(lane_a(0, 0)), 64'h0F0F);
    chk("t7_idle_busy", 64'(bus_a.o_busy[0]), 64'd0);

    // LMFC-aligned start on dut_b; lmfc coincident with trigger is ignored
    bus_b.i_trigger = 1'b1;
    bus_b.i_lmfc = 1'b1;
    step();
    bus_b.i_trigger = 1'b0;
    bus_b.i_lmfc = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 5) bus_b.i_lmfc = 1'b1;
      step();
      if (n == 5) bus_b.i_lmfc = 1'b0;
      chk("t3_data", 64'(bus_b.o_data[0 +: SW]), (n >= 7 && n <= 8) ? 64'h5A5A : 64'h0101);
      chk("t3_busy", 64'(bus_b.o_busy[0]), 64'(n >= 2 && n <= 9));
      chk("t3_done", 64'(bus_b.o_done[0]), 64'(n == 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
